// File: rtl/bridge_pkg.sv
// Shared constants and types for the CPU system-bus bridge: device windows,
// device-select encoding and the full-word byte-enable pattern.
package bridge_pkg;

    localparam logic [31:0] DM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DM_LAST  = 32'h0000_2FFF;
    localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
    localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
    localparam logic [31:0] INT_BASE = 32'h0000_7F20;
    localparam logic [31:0] TC_SIZE  = 32'd12;
    localparam logic [31:0] INT_SIZE = 32'd4;

    localparam logic [3:0]  BE_WORD  = 4'b1111;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_DM   = 3'd1,
        SEL_TC0  = 3'd2,
        SEL_TC1  = 3'd3,
        SEL_INT  = 3'd4
    } dev_sel_e;

    localparam int unsigned SEL_W = 5;

    // Inclusive window test; last is base + size - 1.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] last);
        return (addr >= base) && (addr <= last);
    endfunction

endpackage

// File: rtl/bridge_addr_decode.sv
// Address decoder: maps a CPU byte address to a one-hot device select,
// indexed by dev_sel_e, with SEL_NONE set for unmapped addresses.
module bridge_addr_decode
    import bridge_pkg::*;
(
    input  logic [31:0]      addr,
    output logic [SEL_W-1:0] sel
);

    logic hit_dm_s;
    logic hit_t0_s;
    logic hit_t1_s;
    logic hit_int_s;

    assign hit_dm_s  = in_window(addr, DM_BASE,  DM_LAST);
    assign hit_t0_s  = in_window(addr, TC0_BASE, TC0_BASE + TC_SIZE  - 32'd1);
    assign hit_t1_s  = in_window(addr, TC1_BASE, TC1_BASE + TC_SIZE  - 32'd1);
    assign hit_int_s = in_window(addr, INT_BASE, INT_BASE + INT_SIZE - 32'd1);

    // Windows are disjoint, so at most one hit bit is ever set.
    always_comb begin
        sel           = '0;
        sel[SEL_DM]   = hit_dm_s;
        sel[SEL_TC0]  = hit_t0_s;
        sel[SEL_TC1]  = hit_t1_s;
        sel[SEL_INT]  = hit_int_s;
        sel[SEL_NONE] = ~(hit_dm_s | hit_t0_s | hit_t1_s | hit_int_s);
    end

endmodule

// File: rtl/sys_bridge.sv
// System-bus bridge between the CPU memory stage and DM/TC0/TC1/INT.
// Optional sticky bus-error flag enabled by BRIDGE_BUS_ERR_EN.
module sys_bridge
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    output logic [31:0] mem_addr,
    output logic [31:0] timer0_addr,
    output logic [31:0] timer1_addr,
    output logic [31:0] int_addr,
    output logic [31:0] mem_writedata,
    output logic [31:0] timer0_writedata,
    output logic [31:0] timer1_writedata,
    output logic [31:0] int_writedata,
    input  logic [31:0] mem_readdata,
    input  logic [31:0] timer0_readdata,
    input  logic [31:0] timer1_readdata,
    input  logic [31:0] int_readdata,
    output logic        mem_we,
    output logic        timer0_we,
    output logic        timer1_we,
    output logic        int_we,
    output logic [3:0]  mem_be,
    output logic [3:0]  timer0_be,
    output logic [3:0]  timer1_be,
`ifdef BRIDGE_BUS_ERR_EN
    output logic [3:0]  int_be,
    output logic        cpu_err
`else
    output logic [3:0]  int_be
`endif
);

    logic [SEL_W-1:0] sel_s;
    logic             be_any_s;
    logic             be_word_s;

    bridge_addr_decode u_decode (
        .addr (cpu_addr),
        .sel  (sel_s)
    );

    assign be_any_s  = (cpu_be != 4'b0000);
    assign be_word_s = (cpu_be == BE_WORD);

    assign mem_addr         = cpu_addr;
    assign timer0_addr      = cpu_addr;
    assign timer1_addr      = cpu_addr;
    assign int_addr         = cpu_addr;
    assign mem_writedata    = cpu_writedata;
    assign timer0_writedata = cpu_writedata;
    assign timer1_writedata = cpu_writedata;
    assign int_writedata    = cpu_writedata;

    assign mem_be    = sel_s[SEL_DM]  ? cpu_be : 4'b0000;
    assign timer0_be = sel_s[SEL_TC0] ? cpu_be : 4'b0000;
    assign timer1_be = sel_s[SEL_TC1] ? cpu_be : 4'b0000;
    assign int_be    = sel_s[SEL_INT] ? cpu_be : 4'b0000;

    // Timers accept whole-word stores only; partial stores are dropped.
    assign mem_we    = cpu_we & sel_s[SEL_DM]  & be_any_s;
    assign int_we    = cpu_we & sel_s[SEL_INT] & be_any_s;
    assign timer0_we = cpu_we & sel_s[SEL_TC0] & be_word_s;
    assign timer1_we = cpu_we & sel_s[SEL_TC1] & be_word_s;

    // Zero-latency read mux, independent of cpu_we; unmapped reads return zero.
    always_comb begin
        cpu_readdata = 32'h0000_0000;
        if (sel_s[SEL_DM]) begin
            cpu_readdata = mem_readdata;
        end else if (sel_s[SEL_TC0]) begin
            cpu_readdata = timer0_readdata;
        end else if (sel_s[SEL_TC1]) begin
            cpu_readdata = timer1_readdata;
        end else if (sel_s[SEL_INT]) begin
            cpu_readdata = int_readdata;
        end else begin
            cpu_readdata = 32'h0000_0000;
        end
    end

`ifdef BRIDGE_BUS_ERR_EN
    logic err_set_s;
    logic cpu_err_r;

    assign err_set_s = (sel_s[SEL_NONE] & (cpu_we | be_any_s))
                     | (cpu_we & (sel_s[SEL_TC0] | sel_s[SEL_TC1]) & ~be_word_s);

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_err_r <= 1'b0;
        end else if (err_set_s) begin
            cpu_err_r <= 1'b1;
        end else begin
            cpu_err_r <= cpu_err_r;
        end
    end

    assign cpu_err = cpu_err_r;
`else
    logic unused_clk_reset_s;
    assign unused_clk_reset_s = &{1'b0, clk, reset};
`endif

endmodule

// File: tb/tb_sys_bridge.sv
// Directed self-checking bench for sys_bridge; error-flag steps are built
// only when BRIDGE_BUS_ERR_EN is defined.
module tb_sys_bridge;

    logic        clk;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_we;
    logic [3:0]  cpu_be;
    logic [31:0] mem_addr, timer0_addr, timer1_addr, int_addr;
    logic [31:0] mem_writedata, timer0_writedata, timer1_writedata, int_writedata;
    logic [31:0] mem_readdata, timer0_readdata, timer1_readdata, int_readdata;
    logic        mem_we, timer0_we, timer1_we, int_we;
    logic [3:0]  mem_be, timer0_be, timer1_be, int_be;
`ifdef BRIDGE_BUS_ERR_EN
    logic        cpu_err;
`endif

    int checks = 0;
    int errors = 0;

    sys_bridge dut (
        .clk              (clk),
        .reset            (reset),
        .cpu_addr         (cpu_addr),
        .cpu_writedata    (cpu_writedata),
        .cpu_readdata     (cpu_readdata),
        .cpu_we           (cpu_we),
        .cpu_be           (cpu_be),
        .mem_addr         (mem_addr),
        .timer0_addr      (timer0_addr),
        .timer1_addr      (timer1_addr),
        .int_addr         (int_addr),
        .mem_writedata    (mem_writedata),
        .timer0_writedata (timer0_writedata),
        .timer1_writedata (timer1_writedata),
        .int_writedata    (int_writedata),
        .mem_readdata     (mem_readdata),
        .timer0_readdata  (timer0_readdata),
        .timer1_readdata  (timer1_readdata),
        .int_readdata     (int_readdata),
        .mem_we           (mem_we),
        .timer0_we        (timer0_we),
        .timer1_we        (timer1_we),
        .int_we           (int_we),
        .mem_be           (mem_be),
        .timer0_be        (timer0_be),
        .timer1_be        (timer1_be),
`ifdef BRIDGE_BUS_ERR_EN
        .int_be           (int_be),
        .cpu_err          (cpu_err)
`else
        .int_be           (int_be)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a bus cycle and let combinational outputs settle.
    task automatic drive(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd);
        cpu_addr      = a;
        cpu_we        = we;
        cpu_be        = be;
        cpu_writedata = wd;
        #1;
    endtask

    // Packed view of all four we bits {mem,t0,t1,int} and be nibbles.
    function automatic logic [31:0] we_vec();
        return {28'd0, mem_we, timer0_we, timer1_we, int_we};
    endfunction

    function automatic logic [31:0] be_vec();
        return {16'd0, mem_be, timer0_be, timer1_be, int_be};
    endfunction

    initial begin
        reset           = 1'b1;
        cpu_addr        = 32'h0;
        cpu_we          = 1'b0;
        cpu_be          = 4'b0000;
        cpu_writedata   = 32'h0;
        mem_readdata    = 32'd1;
        timer0_readdata = 32'd2;
        timer1_readdata = 32'd3;
        timer_int_init();
        #2;
        check("reset_we_idle", we_vec(), 32'h0);
`ifdef BRIDGE_BUS_ERR_EN
        check("reset_err", {31'd0, cpu_err}, 32'h0);
`endif
        #10;
        reset = 1'b0;

        // DM byte store
        drive(32'h0000_0104, 1'b1, 4'b0010, 32'hAABB_CCDD);
        check("dm_we", we_vec(), 32'h8);
        check("dm_be", be_vec(), 32'h2000);
        check("dm_wd", mem_writedata, 32'hAABB_CCDD);
        check("dm_t1_wd", timer1_writedata, 32'hAABB_CCDD);
        check("dm_addr", mem_addr, 32'h0000_0104);

        // TC1 word then partial store
        drive(32'h0000_7F14, 1'b1, 4'b1111, 32'h1234_5678);
        check("t1_word_we", we_vec(), 32'h2);
        check("t1_word_be", be_vec(), 32'h00F0);
        drive(32'h0000_7F14, 1'b1, 4'b0001, 32'h1234_5678);
        check("t1_part_we", we_vec(), 32'h0);
        check("t1_part_be", be_vec(), 32'h0010);

        // TC0 partial store dropped, word store accepted
        drive(32'h0000_7F08, 1'b1, 4'b0011, 32'h0);
        check("t0_part_we", we_vec(), 32'h0);
        drive(32'h0000_7F0B, 1'b1, 4'b1111, 32'h0);
        check("t0_last_we", we_vec(), 32'h4);

        // Read mux
        drive(32'h0000_0000, 1'b0, 4'b1111, 32'h0);
        check("rd_dm", cpu_readdata, 32'd1);
        check("rd_dm_we", we_vec(), 32'h0);
        drive(32'h0000_7F04, 1'b0, 4'b1111, 32'h0);
        check("rd_t0", cpu_readdata, 32'd2);
        drive(32'h0000_7F18, 1'b0, 4'b1111, 32'h0);
        check("rd_t1", cpu_readdata, 32'd3);
        drive(32'h0000_7F20, 1'b0, 4'b1111, 32'h0);
        check("rd_int", cpu_readdata, 32'd4);
        drive(32'h0000_7F30, 1'b0, 4'b1111, 32'h0);
        check("rd_unmapped", cpu_readdata, 32'd0);
        drive(32'h0000_7F18, 1'b1, 4'b1111, 32'h0);
        check("rd_during_store", cpu_readdata, 32'd3);

        // Boundaries
        drive(32'h0000_2FFF, 1'b1, 4'b1000, 32'h0);
        check("b_2fff_we", we_vec(), 32'h8);
        check("b_2fff_rd", cpu_readdata, 32'd1);
        drive(32'h0000_3000, 1'b1, 4'b1111, 32'h0);
        check("b_3000_we", we_vec(), 32'h0);
        check("b_3000_be", be_vec(), 32'h0);
        check("b_3000_rd", cpu_readdata, 32'd0);
        drive(32'h0000_7F0C, 1'b1, 4'b1111, 32'h0);
        check("b_7f0c_we", we_vec(), 32'h0);
        check("b_7f0c_be", be_vec(), 32'h0);
        check("b_7f0c_rd", cpu_readdata, 32'd0);
        drive(32'h0000_7F1B, 1'b0, 4'b1111, 32'h0);
        check("b_7f1b_rd", cpu_readdata, 32'd3);
        drive(32'h0000_7F1C, 1'b1, 4'b1111, 32'h0);
        check("b_7f1c_we", we_vec(), 32'h0);
        check("b_7f1c_be", be_vec(), 32'h0);
        check("b_7f1c_rd", cpu_readdata, 32'd0);
        drive(32'h0000_7F23, 1'b0, 4'b1111, 32'h0);
        check("b_7f23_rd", cpu_readdata, 32'd4);
        drive(32'h0000_7F24, 1'b1, 4'b1111, 32'h0);
        check("b_7f24_we", we_vec(), 32'h0);
        check("b_7f24_be", be_vec(), 32'h0);
        check("b_7f24_rd", cpu_readdata, 32'd0);

        // INT ack
        drive(32'h0000_7F20, 1'b1, 4'b1111, 32'hDEAD_BEEF);
        check("int_we", we_vec(), 32'h1);
        check("int_be", be_vec(), 32'h000F);
        check("int_addr", int_addr, 32'h0000_7F20);
        check("int_wd", int_writedata, 32'hDEAD_BEEF);

        // DM store with no byte enables writes nothing
        drive(32'h0000_0010, 1'b1, 4'b0000, 32'h0);
        check("dm_be0_we", we_vec(), 32'h0);

        // Reset does not affect combinational outputs
        reset = 1'b1;
        drive(32'h0000_0020, 1'b1, 4'b1111, 32'h0);
        check("reset_dm_we", we_vec(), 32'h8);
        drive(32'h0000_0020, 1'b0, 4'b1111, 32'h0);
        check("reset_idle_we", we_vec(), 32'h0);

`ifdef BRIDGE_BUS_ERR_EN
        check("err_in_reset", {31'd0, cpu_err}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(32'h0000_0020, 1'b0, 4'b1111, 32'h0);
        @(posedge clk); #1;
        check("err_legal_read", {31'd0, cpu_err}, 32'h0);
        @(negedge clk);
        drive(32'h0000_4000, 1'b1, 4'b1111, 32'h0);
        check("err_before_edge", {31'd0, cpu_err}, 32'h0);
        @(posedge clk); #1;
        check("err_set", {31'd0, cpu_err}, 32'h1);
        drive(32'h0000_0000, 1'b0, 4'b1111, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("err_sticky", {31'd0, cpu_err}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("err_async_clear", {31'd0, cpu_err}, 32'h0);
        reset = 1'b0;
        drive(32'h0000_7F04, 1'b1, 4'b0001, 32'h0);
        @(posedge clk); #1;
        check("err_timer_partial", {31'd0, cpu_err}, 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic timer_int_init();
        int_readdata = 32'd4;
    endtask

endmodule
